// File: rtl/pac_life_ctrl.sv
// ---------------------------------------------------------------------------
// pac_life_ctrl
//
// Game-flow controller for the Pac-Man style game. It sits directly after the
// ghost-crash detector and sequences each round: a READY delay, PLAY, the
// DYING animation, a one-cycle RESPAWN, and finally OVER or WIN. All outputs
// are registered or decoded from registered state, so no input reaches an
// output combinationally.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   frame_tick in   one-cycle strobe per video frame
//   start      in   start button (level, debounced)
//   crash      in   Pac-Man/ghost collision flag (level)
//   all_eaten  in   all pellets consumed (level)
//   state      out  IDLE=0 READY=1 PLAY=2 DYING=3 RESPAWN=4 OVER=5 WIN=6
//   lives      out  remaining lives
//   freeze     out  1 = movers hold position (every state except PLAY)
//   respawn    out  1-cycle pulse: reload character start positions
//   invuln     out  crash immunity active
//   game_over  out  high while in OVER
//   win        out  high while in WIN
// ---------------------------------------------------------------------------
module pac_life_ctrl #(
  parameter int LIVES_INIT    = 3,
  parameter int READY_FRAMES  = 120,
  parameter int DEATH_FRAMES  = 60,
  parameter int INVULN_FRAMES = 90
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       crash,
  input  logic       all_eaten,
  output logic [2:0] state,
  output logic [2:0] lives,
  output logic       freeze,
  output logic       respawn,
  output logic       invuln,
  output logic       game_over,
  output logic       win
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_READY   = 3'd1;
  localparam logic [2:0] ST_PLAY    = 3'd2;
  localparam logic [2:0] ST_DYING   = 3'd3;
  localparam logic [2:0] ST_RESPAWN = 3'd4;
  localparam logic [2:0] ST_OVER    = 3'd5;
  localparam logic [2:0] ST_WIN     = 3'd6;

  localparam logic [2:0] LIVES_RELOAD = 3'(LIVES_INIT);
  localparam logic [7:0] READY_LAST   = 8'(READY_FRAMES - 1);
  localparam logic [7:0] DEATH_LAST   = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] INVULN_LAST  = 8'(INVULN_FRAMES - 1);

  logic [7:0] frame_cnt;
  logic [7:0] invuln_cnt;
  logic       invuln_pending;

  // Round sequencer. A frame_tick on a transition edge is consumed by the old
  // state; the new state always starts its counter from zero. invuln_pending
  // carries "this life came from a death" across RESPAWN/READY so that
  // immunity only begins once play resumes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      lives          <= LIVES_RELOAD;
      frame_cnt      <= 8'd0;
      invuln         <= 1'b0;
      invuln_cnt     <= 8'd0;
      invuln_pending <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_OVER, ST_WIN: begin
          lives          <= LIVES_RELOAD;
          invuln_pending <= 1'b0;
          invuln         <= 1'b0;
          frame_cnt      <= 8'd0;
          if (start) begin
            state <= ST_RESPAWN;
          end
        end

        ST_RESPAWN: begin
          state     <= ST_READY;
          frame_cnt <= 8'd0;
        end

        ST_READY: begin
          if (frame_tick) begin
            if (frame_cnt == READY_LAST) begin
              state     <= ST_PLAY;
              frame_cnt <= 8'd0;
              if (invuln_pending) begin
                invuln         <= 1'b1;
                invuln_cnt     <= 8'd0;
                invuln_pending <= 1'b0;
              end
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end

        // Clearing the level beats a simultaneous crash; a crash only counts
        // when immunity is not active.
        ST_PLAY: begin
          if (all_eaten) begin
            state  <= ST_WIN;
            invuln <= 1'b0;
          end else if (crash && !invuln) begin
            state     <= ST_DYING;
            lives     <= (lives == 3'd0) ? 3'd0 : lives - 3'd1;
            frame_cnt <= 8'd0;
            invuln    <= 1'b0;
          end else if (invuln && frame_tick) begin
            if (invuln_cnt == INVULN_LAST) begin
              invuln <= 1'b0;
            end else begin
              invuln_cnt <= invuln_cnt + 8'd1;
            end
          end
        end

        ST_DYING: begin
          if (frame_tick) begin
            if (frame_cnt == DEATH_LAST) begin
              frame_cnt <= 8'd0;
              if (lives == 3'd0) begin
                state <= ST_OVER;
              end else begin
                state          <= ST_RESPAWN;
                invuln_pending <= 1'b1;
              end
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end

        // Unused encoding: fall back to a clean idle.
        default: begin
          state          <= ST_IDLE;
          frame_cnt      <= 8'd0;
          invuln         <= 1'b0;
          invuln_pending <= 1'b0;
        end
      endcase
    end
  end

  assign freeze    = (state != ST_PLAY);
  assign respawn   = (state == ST_RESPAWN);
  assign game_over = (state == ST_OVER);
  assign win       = (state == ST_WIN);

endmodule

// File: tb/tb_pac_life_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pac_life_ctrl
//
// Directed bench for pac_life_ctrl with LIVES_INIT=2, READY_FRAMES=3,
// DEATH_FRAMES=4, INVULN_FRAMES=2. Inputs change 1 ns after a rising edge
// and outputs are sampled at the same point, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_pac_life_ctrl;

  localparam logic [7:0] S_IDLE    = 8'd0;
  localparam logic [7:0] S_READY   = 8'd1;
  localparam logic [7:0] S_PLAY    = 8'd2;
  localparam logic [7:0] S_DYING   = 8'd3;
  localparam logic [7:0] S_RESPAWN = 8'd4;
  localparam logic [7:0] S_OVER    = 8'd5;
  localparam logic [7:0] S_WIN     = 8'd6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       crash = 1'b0;
  logic       all_eaten = 1'b0;
  logic [2:0] state;
  logic [2:0] lives;
  logic       freeze;
  logic       respawn;
  logic       invuln;
  logic       game_over;
  logic       win;

  int tests_run = 0;
  int tests_failed = 0;

  pac_life_ctrl #(
    .LIVES_INIT   (2),
    .READY_FRAMES (3),
    .DEATH_FRAMES (4),
    .INVULN_FRAMES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .start     (start),
    .crash     (crash),
    .all_eaten (all_eaten),
    .state     (state),
    .lives     (lives),
    .freeze    (freeze),
    .respawn   (respawn),
    .invuln    (invuln),
    .game_over (game_over),
    .win       (win)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then advance to 1 ns after the rising edge.
  task automatic apply_stimulus(input logic s, input logic c, input logic a,
                                input logic t);
    start      = s;
    crash      = c;
    all_eaten  = a;
    frame_tick = t;
    @(posedge clk);
    #1;
    start      = 1'b0;
    crash      = 1'b0;
    all_eaten  = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic check_output(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Checks every output in one go.
  task automatic check_all(input string tag, input logic [7:0] st,
                           input logic [7:0] lv, input logic fz,
                           input logic rs, input logic iv,
                           input logic go, input logic wn);
    check_output({tag, ".state"},     {5'd0, state}, st);
    check_output({tag, ".lives"},     {5'd0, lives}, lv);
    check_output({tag, ".freeze"},    {7'd0, freeze}, {7'd0, fz});
    check_output({tag, ".respawn"},   {7'd0, respawn}, {7'd0, rs});
    check_output({tag, ".invuln"},    {7'd0, invuln}, {7'd0, iv});
    check_output({tag, ".game_over"}, {7'd0, game_over}, {7'd0, go});
    check_output({tag, ".win"},       {7'd0, win}, {7'd0, wn});
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    apply_stimulus(0, 0, 0, 0);
    check_all("reset", S_IDLE, 2, 1, 0, 0, 0, 0);
    rst = 1'b0;
    apply_stimulus(0, 0, 0, 0);
    check_all("idle_hold", S_IDLE, 2, 1, 0, 0, 0, 0);

    // First game: start -> RESPAWN -> READY -> PLAY on 3rd tick
    apply_stimulus(1, 0, 0, 0);
    check_all("respawn1", S_RESPAWN, 2, 1, 1, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0);
    check_all("ready1", S_READY, 2, 1, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1);
    check_all("ready1_tick2", S_READY, 2, 1, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1);
    check_all("play1", S_PLAY, 2, 0, 0, 0, 0, 0);

    // start ignored in PLAY; all_eaten ignored elsewhere is tested in DYING
    apply_stimulus(1, 0, 0, 1);
    check_output("start_in_play", {5'd0, state}, S_PLAY);

    // Crash -> DYING with lives decremented on the same edge
    apply_stimulus(0, 1, 0, 0);
    check_all("dying1", S_DYING, 1, 1, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1);
    apply_stimulus(0, 0, 1, 1);
    apply_stimulus(0, 0, 0, 1);
    check_all("dying1_tick3", S_DYING, 1, 1, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1);
    check_all("respawn2", S_RESPAWN, 1, 1, 1, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0);
    check_output("ready2", {5'd0, state}, S_READY);
    apply_stimulus(0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 1);
    check_all("play2_invuln", S_PLAY, 1, 0, 0, 1, 0, 0);

    // Hold crash through immunity: cleared on 2nd tick, DYING on next cycle
    apply_stimulus(0, 1, 0, 0);
    check_all("invuln_crash", S_PLAY, 1, 0, 0, 1, 0, 0);
    apply_stimulus(0, 1, 0, 1);
    check_all("invuln_tick1", S_PLAY, 1, 0, 0, 1, 0, 0);
    apply_stimulus(0, 1, 0, 1);
    check_all("invuln_tick2", S_PLAY, 1, 0, 0, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0);
    check_all("dying2", S_DYING, 0, 1, 0, 0, 0, 0);

    // Last life lost -> OVER
    apply_stimulus(0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 1);
    check_all("over", S_OVER, 0, 1, 0, 0, 1, 0);
    apply_stimulus(0, 0, 0, 0);
    check_all("over_reload", S_OVER, 2, 1, 0, 0, 1, 0);

    // New game from OVER; tick during RESPAWN does not count toward READY
    apply_stimulus(1, 0, 0, 0);
    check_all("respawn3", S_RESPAWN, 2, 1, 1, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1);
    check_output("ready3", {5'd0, state}, S_READY);
    apply_stimulus(0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 1);
    check_output("ready3_tick2", {5'd0, state}, S_READY);
    apply_stimulus(0, 0, 0, 1);
    check_all("play3_no_invuln", S_PLAY, 2, 0, 0, 0, 0, 0);

    // all_eaten beats crash
    apply_stimulus(0, 1, 1, 0);
    check_all("win", S_WIN, 2, 1, 0, 0, 0, 1);

    // New game from WIN, then reset mid-DYING
    apply_stimulus(1, 0, 0, 0);
    check_output("respawn4", {5'd0, state}, S_RESPAWN);
    apply_stimulus(0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 1);
    check_output("play4", {5'd0, state}, S_PLAY);
    apply_stimulus(0, 1, 0, 0);
    check_output("dying4.lives", {5'd0, lives}, 8'd1);
    apply_stimulus(0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 1);
    rst = 1'b1;
    apply_stimulus(0, 0, 0, 1);
    check_all("reset_mid_dying", S_IDLE, 2, 1, 0, 0, 0, 0);
    rst = 1'b0;

    // Counter restarted by reset: a fresh READY still needs three ticks
    apply_stimulus(1, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 1);
    check_output("ready5_tick2", {5'd0, state}, S_READY);
    apply_stimulus(0, 0, 0, 1);
    check_all("play5", S_PLAY, 2, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
